turn_clock_controller: RTL and testbench

Two-player chess-clock controller for the board game. Keeps a separate remaining-time budget for each player and accepts move requests only from the player whose turn it is. Hands the turn to the other player on each accepted move and declares the game over when a budget runs out. Sits between the per-player move-detect logic and the display/end-game logic, replacing free-running per-turn timing with budget scheduling.

---
 rtl/turn_clock_controller.sv | 171 +++++++++++++++++
 tb/tb_turn_clock_controller.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/turn_clock_controller.sv
// turn_clock_controller
// Two-player chess clock. Each player has a separate remaining-time budget in
// seconds. Only the player whose turn it is may move. An accepted move hands
// the turn to the other player. The game ends when the active budget reaches 0.
// Optional feature: define TURN_CLOCK_INCREMENT_EN to add INC_S seconds
// (saturating) to the mover's budget on every accepted move.
module turn_clock_controller #(
    parameter int TICK_CYCLES = 100_000_000,
    parameter int BUDGET_S    = 120,
    parameter int TIME_W      = 8,
    parameter int INC_S       = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic              pause,
    input  logic [1:0]        move_req,
    output logic              move_ack,
    output logic              illegal_move,
    output logic              player_turn,
    output logic [TIME_W-1:0] time_left0,
    output logic [TIME_W-1:0] time_left1,
    output logic [7:0]        move_count,
    output logic [1:0]        state,
    output logic              end_game,
    output logic              winner
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        OVER   = 2'd3
    } state_t;

    localparam logic [31:0]       TICK_LAST   = 32'(TICK_CYCLES - 1);
    localparam logic [TIME_W-1:0] BUDGET_INIT = TIME_W'(BUDGET_S);
    localparam logic [TIME_W-1:0] ONE_SEC     = TIME_W'(1);

    // Seconds granted to the mover on each accepted move; zero when the
    // increment feature is compiled out, so the budget is rewritten unchanged.
`ifdef TURN_CLOCK_INCREMENT_EN
    localparam logic [TIME_W:0] INC_AMT = (TIME_W+1)'(INC_S);
`else
    localparam logic [TIME_W:0] INC_AMT = (TIME_W+1)'(INC_S * 0);
`endif

    state_t      state_r;
    logic [31:0] prescaler;

    logic       start_d, start_dd;
    logic       pause_d, pause_dd;
    logic [1:0] move_d, move_dd;

    logic       start_edge;
    logic       pause_edge;
    logic [1:0] move_edge;
    logic       mover_move;
    logic       other_move;
    logic [TIME_W-1:0] active_left;

    // Saturating add of the increment to a budget.
    function automatic logic [TIME_W-1:0] add_inc(input logic [TIME_W-1:0] value);
        logic [TIME_W:0] sum;
        sum = {1'b0, value} + INC_AMT;
        if (sum[TIME_W])
            add_inc = '1;
        else
            add_inc = sum[TIME_W-1:0];
    endfunction

    assign start_edge  = start_d & ~start_dd;
    assign pause_edge  = pause_d & ~pause_dd;
    assign move_edge   = move_d & ~move_dd;
    assign mover_move  = move_edge[player_turn];
    assign other_move  = move_edge[~player_turn];
    assign active_left = player_turn ? time_left1 : time_left0;
    assign state       = state_r;

    // Input registers plus one delayed copy so that only rising edges act.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            start_d  <= 1'b0;
            start_dd <= 1'b0;
            pause_d  <= 1'b0;
            pause_dd <= 1'b0;
            move_d   <= 2'b00;
            move_dd  <= 2'b00;
        end else begin
            start_d  <= start;
            start_dd <= start_d;
            pause_d  <= pause;
            pause_dd <= pause_d;
            move_d   <= move_req;
            move_dd  <= move_d;
        end
    end

    // Game FSM: budgets, prescaler, turn handoff; a pause edge in RUN wins over moves that cycle.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r      <= IDLE;
            player_turn  <= 1'b0;
            end_game     <= 1'b0;
            winner       <= 1'b0;
            move_ack     <= 1'b0;
            illegal_move <= 1'b0;
            move_count   <= 8'd0;
            time_left0   <= BUDGET_INIT;
            time_left1   <= BUDGET_INIT;
            prescaler    <= 32'd0;
        end else begin
            move_ack     <= 1'b0;
            illegal_move <= 1'b0;
            case (state_r)
                IDLE, OVER: begin
                    if (start_edge) begin
                        state_r     <= RUN;
                        time_left0  <= BUDGET_INIT;
                        time_left1  <= BUDGET_INIT;
                        player_turn <= 1'b0;
                        move_count  <= 8'd0;
                        prescaler   <= 32'd0;
                        end_game    <= 1'b0;
                        winner      <= 1'b0;
                    end
                end
                RUN: begin
                    if (pause_edge) begin
                        state_r <= PAUSED;
                    end else begin
                        if (other_move)
                            illegal_move <= 1'b1;
                        if (mover_move) begin
                            move_ack    <= 1'b1;
                            player_turn <= ~player_turn;
                            prescaler   <= 32'd0;
                            if (move_count != 8'hFF)
                                move_count <= move_count + 8'd1;
                            if (player_turn)
                                time_left1 <= add_inc(time_left1);
                            else
                                time_left0 <= add_inc(time_left0);
                        end else if (prescaler == TICK_LAST) begin
                            prescaler <= 32'd0;
                            if (player_turn)
                                time_left1 <= time_left1 - ONE_SEC;
                            else
                                time_left0 <= time_left0 - ONE_SEC;
                            if (active_left == ONE_SEC) begin
                                state_r  <= OVER;
                                end_game <= 1'b1;
                                winner   <= ~player_turn;
                            end
                        end else begin
                            prescaler <= prescaler + 32'd1;
                        end
                    end
                end
                PAUSED: begin
                    if (pause_edge)
                        state_r <= RUN;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_turn_clock_controller.sv
// tb_turn_clock_controller
// Self-checking bench for turn_clock_controller. Main instance uses
// TICK_CYCLES=10, BUDGET_S=3; a second instance with BUDGET_S=254, INC_S=2
// exercises the increment (expected value follows TURN_CLOCK_INCREMENT_EN).
module tb_turn_clock_controller;

    localparam int TICK = 10;
    localparam int BUD  = 3;

`ifdef TURN_CLOCK_INCREMENT_EN
    localparam logic [7:0] INC_T0_AFTER = 8'd255;
`else
    localparam logic [7:0] INC_T0_AFTER = 8'd254;
`endif

    logic       clock = 1'b0;
    logic       resetn;
    logic       start;
    logic       pause;
    logic [1:0] move_req;
    logic       move_ack, illegal_move, player_turn;
    logic [7:0] time_left0, time_left1, move_count;
    logic [1:0] state;
    logic       end_game, winner;

    logic       start_i;
    logic       pause_i;
    logic [1:0] move_req_i;
    logic       move_ack_i, illegal_move_i, player_turn_i;
    logic [7:0] time_left0_i, time_left1_i, move_count_i;
    logic [1:0] state_i;
    logic       end_game_i, winner_i;

    typedef struct {
        logic       ack;
        logic       ill;
        logic       turn;
        logic [7:0] count;
        logic [7:0] t0;
        logic [7:0] t1;
    } resp_t;

    typedef struct {
        int         cyc;
        logic [7:0] t0;
    } tick_t;

    resp_t sb[$];
    tick_t tq[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    turn_clock_controller #(
        .TICK_CYCLES(TICK), .BUDGET_S(BUD), .TIME_W(8), .INC_S(2)
    ) dut (
        .clock(clock), .resetn(resetn), .start(start), .pause(pause),
        .move_req(move_req), .move_ack(move_ack), .illegal_move(illegal_move),
        .player_turn(player_turn), .time_left0(time_left0), .time_left1(time_left1),
        .move_count(move_count), .state(state), .end_game(end_game), .winner(winner)
    );

    turn_clock_controller #(
        .TICK_CYCLES(TICK), .BUDGET_S(254), .TIME_W(8), .INC_S(2)
    ) dut_inc (
        .clock(clock), .resetn(resetn), .start(start_i), .pause(pause_i),
        .move_req(move_req_i), .move_ack(move_ack_i), .illegal_move(illegal_move_i),
        .player_turn(player_turn_i), .time_left0(time_left0_i), .time_left1(time_left1_i),
        .move_count(move_count_i), .state(state_i), .end_game(end_game_i), .winner(winner_i)
    );

    always #5 clock = ~clock;

    // Synchronous reset of both instances; returns on a negedge with reset released.
    task automatic do_reset();
        resetn     = 1'b0;
        start      = 1'b0;
        pause      = 1'b0;
        move_req   = 2'b00;
        start_i    = 1'b0;
        pause_i    = 1'b0;
        move_req_i = 2'b00;
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
    endtask

    // Pulse start and return on the first negedge showing RUN (bounded).
    task automatic start_game(output bit ok);
        ok = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (state == 2'd1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Wait (bounded) for an ack or illegal pulse on the main instance.
    task automatic wait_resp(output bit got);
        got = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (move_ack || illegal_move) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    // Reset defaults, plus reset in the middle of a game.
    task automatic test_reset();
        bit ok;
        do_reset();
        n_tests++;
        if ({state, time_left0, time_left1, end_game, move_count, player_turn, move_ack, illegal_move, winner}
            !== {2'd0, 8'd3, 8'd3, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL reset_defaults: state=%0d t0=%0d t1=%0d end=%0d cnt=%0d turn=%0d ack=%0d ill=%0d win=%0d, want 0 3 3 0 0 0 0 0 0",
                     state, time_left0, time_left1, end_game, move_count, player_turn, move_ack, illegal_move, winner);
        end
        start_game(ok);
        repeat (12) @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        n_tests++;
        if ({state, time_left0, time_left1} !== {2'd0, 8'd3, 8'd3}) begin
            n_fail++;
            $display("[TB] FAIL reset_midgame: state=%0d t0=%0d t1=%0d, want 0 3 3", state, time_left0, time_left1);
        end
    endtask

    // Move requests in IDLE must be ignored.
    task automatic test_idle_moves();
        bit seen = 1'b0;
        do_reset();
        move_req = 2'b11;
        repeat (4) begin
            @(negedge clock);
            if (move_ack || illegal_move) seen = 1'b1;
        end
        move_req = 2'b00;
        n_tests++;
        if ({seen, state} !== {1'b0, 2'd0}) begin
            n_fail++;
            $display("[TB] FAIL idle_moves: pulse_seen=%0d state=%0d, want 0 0", seen, state);
        end
    endtask

    // Player 0 runs out of time with no moves.
    task automatic test_timeout();
        bit ok;
        logic [7:0] prev;
        tick_t e;
        do_reset();
        start_game(ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL timeout_start: state=%0d, want 1", state);
        end
        tq.delete();
        tq.push_back('{10, 8'd2});
        tq.push_back('{20, 8'd1});
        tq.push_back('{30, 8'd0});
        prev = time_left0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (time_left0 !== prev) begin
                prev = time_left0;
                n_tests++;
                if (tq.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL timeout_extra_step: t0=%0d at cycle %0d, want no change", time_left0, c);
                end else begin
                    e = tq.pop_front();
                    if (time_left0 !== e.t0 || c != e.cyc) begin
                        n_fail++;
                        $display("[TB] FAIL timeout_step: t0=%0d at cycle %0d, want %0d at cycle %0d",
                                 time_left0, c, e.t0, e.cyc);
                    end
                end
                if (time_left0 === 8'd0) begin
                    n_tests++;
                    if ({state, end_game, winner, time_left1} !== {2'd3, 1'b1, 1'b1, 8'd3}) begin
                        n_fail++;
                        $display("[TB] FAIL timeout_over: state=%0d end=%0d win=%0d t1=%0d, want 3 1 1 3",
                                 state, end_game, winner, time_left1);
                    end
                end
            end
        end
        n_tests++;
        if (tq.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL timeout_missing_steps: %0d left, want 0", tq.size());
        end
    endtask

    // Illegal request from player 1, then a legal move by player 0.
    task automatic test_handoff();
        bit ok, got;
        resp_t e;
        int k;
        do_reset();
        start_game(ok);
        move_req = 2'b10;
        sb.push_back('{1'b0, 1'b1, 1'b0, 8'd0, 8'd3, 8'd3});
        wait_resp(got);
        move_req = 2'b00;
        e = sb.pop_front();
        n_tests++;
        if (!got || {move_ack, illegal_move, player_turn, move_count, time_left0, time_left1}
                    !== {e.ack, e.ill, e.turn, e.count, e.t0, e.t1}) begin
            n_fail++;
            $display("[TB] FAIL handoff_illegal: got=%0d ack=%0d ill=%0d turn=%0d cnt=%0d, want 1 %0d %0d %0d %0d",
                     got, move_ack, illegal_move, player_turn, move_count, e.ack, e.ill, e.turn, e.count);
        end
        @(negedge clock);
        move_req = 2'b01;
        sb.push_back('{1'b1, 1'b0, 1'b1, 8'd1, 8'd3, 8'd3});
        wait_resp(got);
        move_req = 2'b00;
        e = sb.pop_front();
        n_tests++;
        if (!got || {move_ack, illegal_move, player_turn, move_count, time_left0, time_left1}
                    !== {e.ack, e.ill, e.turn, e.count, e.t0, e.t1}) begin
            n_fail++;
            $display("[TB] FAIL handoff_move: got=%0d ack=%0d ill=%0d turn=%0d cnt=%0d, want 1 %0d %0d %0d %0d",
                     got, move_ack, illegal_move, player_turn, move_count, e.ack, e.ill, e.turn, e.count);
        end
        k = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clock);
            if (time_left1 !== 8'd3) begin
                k = i;
                break;
            end
        end
        n_tests++;
        if (k != TICK || time_left0 !== 8'd3) begin
            n_fail++;
            $display("[TB] FAIL handoff_prescaler: t1 stepped after %0d cycles (t0=%0d), want %0d (t0=3)",
                     k, time_left0, TICK);
        end
    endtask

    // Player 0 moves exactly on the wrap cycle that would take the last second.
    task automatic test_wrap_move();
        bit ok;
        resp_t e;
        do_reset();
        start_game(ok);
        sb.delete();
        for (int c = 1; c <= 45; c++) begin
            @(negedge clock);
            if (c == 28) begin
                move_req = 2'b01;
                sb.push_back('{1'b1, 1'b0, 1'b1, 8'd1, 8'd1, 8'd3});
            end
            if (c == 29) move_req = 2'b00;
            if ((move_ack || illegal_move) && sb.size() != 0) begin
                e = sb.pop_front();
                n_tests++;
                if (c != 30 || {move_ack, illegal_move, player_turn, move_count, time_left0, time_left1}
                               !== {e.ack, e.ill, e.turn, e.count, e.t0, e.t1}) begin
                    n_fail++;
                    $display("[TB] FAIL wrap_move: cycle=%0d ack=%0d ill=%0d turn=%0d cnt=%0d t0=%0d t1=%0d, want cycle 30 %0d %0d %0d %0d %0d %0d",
                             c, move_ack, illegal_move, player_turn, move_count, time_left0, time_left1,
                             e.ack, e.ill, e.turn, e.count, e.t0, e.t1);
                end
            end
            if (c == 30) begin
                n_tests++;
                if (state !== 2'd1) begin
                    n_fail++;
                    $display("[TB] FAIL wrap_state: state=%0d, want 1", state);
                end
            end
            if (c == 39 || c == 40) begin
                n_tests++;
                if (time_left1 !== ((c == 39) ? 8'd3 : 8'd2)) begin
                    n_fail++;
                    $display("[TB] FAIL wrap_next_tick: t1=%0d at cycle %0d, want %0d", time_left1, c, (c == 39) ? 3 : 2);
                end
            end
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL wrap_no_ack: %0d expected responses unseen, want 0", sb.size());
            sb.delete();
        end
    endtask

    // Both players raise requests in the same cycle.
    task automatic test_both_edges();
        bit ok, got;
        resp_t e;
        do_reset();
        start_game(ok);
        move_req = 2'b11;
        sb.push_back('{1'b1, 1'b1, 1'b1, 8'd1, 8'd3, 8'd3});
        wait_resp(got);
        move_req = 2'b00;
        e = sb.pop_front();
        n_tests++;
        if (!got || {move_ack, illegal_move, player_turn, move_count} !== {e.ack, e.ill, e.turn, e.count}) begin
            n_fail++;
            $display("[TB] FAIL both_edges: got=%0d ack=%0d ill=%0d turn=%0d cnt=%0d, want 1 %0d %0d %0d %0d",
                     got, move_ack, illegal_move, player_turn, move_count, e.ack, e.ill, e.turn, e.count);
        end
    endtask

    // Pause mid-second, start ignored while paused, resume, time out, restart.
    task automatic test_pause_restart();
        bit ok, frozen_bad;
        int k;
        do_reset();
        start_game(ok);
        repeat (4) @(negedge clock);
        pause = 1'b1;
        @(negedge clock);
        pause = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (state == 2'd2) begin
                ok = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL pause_enter: state=%0d, want 2", state);
        end
        frozen_bad = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clock);
            if (i == 20) start = 1'b1;
            if (i == 21) start = 1'b0;
            if (time_left0 !== 8'd3 || time_left1 !== 8'd3 || state !== 2'd2) frozen_bad = 1'b1;
        end
        n_tests++;
        if (frozen_bad) begin
            n_fail++;
            $display("[TB] FAIL pause_frozen: state=%0d t0=%0d t1=%0d during pause, want 2 3 3", state, time_left0, time_left1);
        end
        pause = 1'b1;
        @(negedge clock);
        pause = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (state == 2'd1) break;
        end
        k = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clock);
            if (time_left0 !== 8'd3) begin
                k = i;
                break;
            end
        end
        n_tests++;
        if (k < 4 || k > 6) begin
            n_fail++;
            $display("[TB] FAIL pause_resume: t0 stepped %0d cycles after resume, want 4..6", k);
        end
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (state == 2'd3) begin
                ok = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!ok || winner !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL pause_over: reached=%0d winner=%0d, want 1 1", ok, winner);
        end
        start_game(ok);
        n_tests++;
        if (!ok || {time_left0, time_left1, end_game, player_turn, move_count} !== {8'd3, 8'd3, 1'b0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("[TB] FAIL restart: run=%0d t0=%0d t1=%0d end=%0d turn=%0d cnt=%0d, want 1 3 3 0 0 0",
                     ok, time_left0, time_left1, end_game, player_turn, move_count);
        end
    endtask

    // Increment instance: move by player 0 then by player 1 at budget 254.
    task automatic test_increment();
        bit ok, got;
        resp_t e;
        do_reset();
        start_i = 1'b1;
        @(negedge clock);
        start_i = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (state_i == 2'd1) begin
                ok = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL inc_start: state=%0d, want 1", state_i);
        end
        for (int m = 0; m < 2; m++) begin
            move_req_i = (m == 0) ? 2'b01 : 2'b10;
            sb.push_back('{1'b1, 1'b0, (m == 0), 8'(m + 1), INC_T0_AFTER, (m == 0) ? 8'd254 : INC_T0_AFTER});
            got = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clock);
                if (move_ack_i) begin
                    got = 1'b1;
                    break;
                end
            end
            move_req_i = 2'b00;
            e = sb.pop_front();
            n_tests++;
            if (!got || {move_ack_i, illegal_move_i, player_turn_i, move_count_i, time_left0_i, time_left1_i}
                        !== {e.ack, e.ill, e.turn, e.count, e.t0, e.t1}) begin
                n_fail++;
                $display("[TB] FAIL increment_move%0d: got=%0d turn=%0d cnt=%0d t0=%0d t1=%0d, want 1 %0d %0d %0d %0d",
                         m, got, player_turn_i, move_count_i, time_left0_i, time_left1_i, e.turn, e.count, e.t0, e.t1);
            end
            @(negedge clock);
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_idle_moves();
        test_timeout();
        test_handoff();
        test_wrap_move();
        test_both_edges();
        test_pause_restart();
        test_increment();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
